decode_stage: RTL and testbench

Second pipeline stage: decodes the instruction word latched by fetch, reads the 32×32 register bank, resolves jumps and branches in the same cycle, and drives the PC-redirect controls back to fetch. Registered control and operand outputs go to the execute stage. Writes from writeback land in the register bank. The stage squashes the one wrong-path instruction that follows a taken redirect.

---
 rtl/decode_stage_pkg.sv | 65 ++++++
 rtl/decode_stage_reg_bank.sv | 30 +++
 rtl/decode_stage.sv | 173 +++++++++++++++++
 tb/tb_decode_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcode/funct encodings, ALU and PC-redirect codes,
// the NOP word and the decode-to-execute pipeline record.
package decode_stage_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [31:0] NOP_WORD = 32'd0;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b100,
      ALU_SLL = 3'b101,
      ALU_SRL = 3'b110
   } aluop_t;

   typedef enum logic [1:0] {
      PC_BRANCH = 2'b00,
      PC_REG    = 2'b01,
      PC_JUMP   = 2'b10,
      PC_EXC    = 2'b11
   } pctype_t;

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_FLUSH  = 1'b1
   } state_t;

   typedef struct packed {
      logic [31:0] rega;
      logic [31:0] regb;
      logic [31:0] imedext;
      logic [31:0] nextpc;
      logic [4:0]  regdest;
      aluop_t      aluop;
      logic        selimregb;
      logic        readmem;
      logic        writemem;
      logic        regwrite;
      logic        sellink;
   } id_ex_t;

   function automatic logic [31:0] sext16(input logic [15:0] value);
      return {{16{value[15]}}, value};
   endfunction

endpackage

// File: rtl/decode_stage_reg_bank.sv
// 32x32 register bank, two async read ports and one posedge write port.
// r0 is hardwired to zero; a same-cycle write to a read index bypasses to that read port.
module reg_bank (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  raddr_a,
   input  logic [4:0]  raddr_b,
   output logic [31:0] rdata_a,
   output logic [31:0] rdata_b,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata
);

   logic [31:0] regs [32];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && waddr != 5'd0) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = (raddr_a == 5'd0)                ? 32'd0 :
                    (we && waddr == raddr_a)         ? wdata : regs[raddr_a];
   assign rdata_b = (raddr_b == 5'd0)                ? 32'd0 :
                    (we && waddr == raddr_b)         ? wdata : regs[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: combinational redirect to fetch, 1-cycle registered controls to execute.
// A stall or a post-redirect FLUSH cycle issues a bubble and suppresses redirects.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'd64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] if_id_instruc,
   input  logic [31:0] if_id_nextpc,
   input  logic        ex_if_stall,
   input  logic        wb_id_regwrite,
   input  logic [4:0]  wb_id_regdest,
   input  logic [31:0] wb_id_writedata,
   output logic        id_if_selpcsource,
   output logic [1:0]  id_if_selpctype,
   output logic [31:0] id_if_pcimd2ext,
   output logic [31:0] id_if_rega,
   output logic [31:0] id_if_pcindex,
   output logic [31:0] id_ex_rega,
   output logic [31:0] id_ex_regb,
   output logic [31:0] id_ex_imedext,
   output logic [31:0] id_ex_nextpc,
   output logic [4:0]  id_ex_regdest,
   output logic [2:0]  id_ex_aluop,
   output logic        id_ex_selimregb,
   output logic        id_ex_readmem,
   output logic        id_ex_writemem,
   output logic        id_ex_regwrite,
   output logic        id_ex_sellink
);

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] rs_val, rt_val, imm_ext;
   logic        redirect, undef, bubble;
   pctype_t     pctype;
   id_ex_t      ctl, id_ex_d, id_ex_q;
   state_t      state;

   assign op      = if_id_instruc[31:26];
   assign rs      = if_id_instruc[25:21];
   assign rt      = if_id_instruc[20:16];
   assign rd      = if_id_instruc[15:11];
   assign funct   = if_id_instruc[5:0];
   assign imm_ext = sext16(if_id_instruc[15:0]);

   reg_bank u_reg_bank (
      .clock   (clock),
      .reset   (reset),
      .raddr_a (rs),
      .raddr_b (rt),
      .rdata_a (rs_val),
      .rdata_b (rt_val),
      .we      (wb_id_regwrite),
      .waddr   (wb_id_regdest),
      .wdata   (wb_id_writedata)
   );

   always_comb begin
      ctl           = '0;
      ctl.rega      = rs_val;
      ctl.regb      = rt_val;
      ctl.imedext   = imm_ext;
      ctl.nextpc    = if_id_nextpc + 32'd4;
      ctl.aluop     = ALU_ADD;
      redirect      = 1'b0;
      undef         = 1'b0;
      pctype        = PC_BRANCH;
      case (op)
         OP_RTYPE: begin
            ctl.regwrite = 1'b1;
            ctl.regdest  = rd;
            case (funct)
               FN_ADD: ctl.aluop = ALU_ADD;
               FN_SUB: ctl.aluop = ALU_SUB;
               FN_AND: ctl.aluop = ALU_AND;
               FN_OR:  ctl.aluop = ALU_OR;
               FN_SLT: ctl.aluop = ALU_SLT;
               FN_SLL: ctl.aluop = ALU_SLL;
               FN_SRL: ctl.aluop = ALU_SRL;
               FN_JR: begin
                  ctl.regwrite = 1'b0;
                  ctl.regdest  = 5'd0;
                  redirect     = 1'b1;
                  pctype       = PC_REG;
               end
               default: undef = 1'b1;
            endcase
         end
         OP_ADDI: begin
            ctl.selimregb = 1'b1;
            ctl.regwrite  = 1'b1;
            ctl.regdest   = rt;
         end
         OP_LW: begin
            ctl.selimregb = 1'b1;
            ctl.readmem   = 1'b1;
            ctl.regwrite  = 1'b1;
            ctl.regdest   = rt;
         end
         OP_SW: begin
            ctl.selimregb = 1'b1;
            ctl.writemem  = 1'b1;
         end
         OP_BEQ: begin
            ctl.aluop = ALU_SUB;
            redirect  = (rs_val == rt_val);
         end
         OP_BNE: begin
            ctl.aluop = ALU_SUB;
            redirect  = (rs_val != rt_val);
         end
         OP_J: begin
            redirect = 1'b1;
            pctype   = PC_JUMP;
         end
         OP_JAL: begin
            redirect     = 1'b1;
            pctype       = PC_JUMP;
            ctl.regwrite = 1'b1;
            ctl.regdest  = 5'd31;
            ctl.sellink  = 1'b1;
         end
         default: undef = 1'b1;
      endcase
      if (undef) begin
         redirect = 1'b1;
         pctype   = PC_EXC;
      end
   end

   assign bubble  = ex_if_stall || (state == ST_FLUSH) || undef;
   assign id_ex_d = bubble ? id_ex_t'('0) : ctl;

   assign id_if_selpcsource = redirect && (state == ST_NORMAL) && !ex_if_stall;
   assign id_if_selpctype   = pctype;
   assign id_if_pcimd2ext   = if_id_nextpc + 32'd4 + (imm_ext << 2);
   assign id_if_rega        = rs_val;
   // Fetch uses its own exception vector; showing it here keeps traces readable.
   assign id_if_pcindex     = undef ? EXC_VECTOR
                                    : {if_id_nextpc[31:28], if_id_instruc[25:0], 2'b00};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         id_ex_q <= '0;
         state   <= ST_NORMAL;
      end else begin
         id_ex_q <= id_ex_d;
         if (!ex_if_stall) begin
            case (state)
               ST_NORMAL: if (redirect) state <= ST_FLUSH;
               ST_FLUSH:  state <= ST_NORMAL;
               default:   state <= ST_NORMAL;
            endcase
         end
      end
   end

   assign id_ex_rega      = id_ex_q.rega;
   assign id_ex_regb      = id_ex_q.regb;
   assign id_ex_imedext   = id_ex_q.imedext;
   assign id_ex_nextpc    = id_ex_q.nextpc;
   assign id_ex_regdest   = id_ex_q.regdest;
   assign id_ex_aluop     = id_ex_q.aluop;
   assign id_ex_selimregb = id_ex_q.selimregb;
   assign id_ex_readmem   = id_ex_q.readmem;
   assign id_ex_writemem  = id_ex_q.writemem;
   assign id_ex_regwrite  = id_ex_q.regwrite;
   assign id_ex_sellink   = id_ex_q.sellink;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: vector table plus hand sequences for flush, stall, bypass and reset.
module tb_decode_stage;
   import decode_stage_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] if_id_instruc, if_id_nextpc;
   logic        ex_if_stall, wb_id_regwrite;
   logic [4:0]  wb_id_regdest;
   logic [31:0] wb_id_writedata;
   logic        id_if_selpcsource;
   logic [1:0]  id_if_selpctype;
   logic [31:0] id_if_pcimd2ext, id_if_rega, id_if_pcindex;
   logic [31:0] id_ex_rega, id_ex_regb, id_ex_imedext, id_ex_nextpc;
   logic [4:0]  id_ex_regdest;
   logic [2:0]  id_ex_aluop;
   logic        id_ex_selimregb, id_ex_readmem, id_ex_writemem, id_ex_regwrite, id_ex_sellink;
   logic [12:0] act_ctl;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   decode_stage #(.EXC_VECTOR(32'd64)) dut (
      .clock(clock), .reset(reset),
      .if_id_instruc(if_id_instruc), .if_id_nextpc(if_id_nextpc),
      .ex_if_stall(ex_if_stall),
      .wb_id_regwrite(wb_id_regwrite), .wb_id_regdest(wb_id_regdest),
      .wb_id_writedata(wb_id_writedata),
      .id_if_selpcsource(id_if_selpcsource), .id_if_selpctype(id_if_selpctype),
      .id_if_pcimd2ext(id_if_pcimd2ext), .id_if_rega(id_if_rega),
      .id_if_pcindex(id_if_pcindex),
      .id_ex_rega(id_ex_rega), .id_ex_regb(id_ex_regb),
      .id_ex_imedext(id_ex_imedext), .id_ex_nextpc(id_ex_nextpc),
      .id_ex_regdest(id_ex_regdest), .id_ex_aluop(id_ex_aluop),
      .id_ex_selimregb(id_ex_selimregb), .id_ex_readmem(id_ex_readmem),
      .id_ex_writemem(id_ex_writemem), .id_ex_regwrite(id_ex_regwrite),
      .id_ex_sellink(id_ex_sellink)
   );

   assign act_ctl = {id_ex_regwrite, id_ex_readmem, id_ex_writemem, id_ex_selimregb,
                     id_ex_sellink, id_ex_aluop, id_ex_regdest};

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        stall;
      logic        e_src;
      logic [1:0]  e_type;
      logic [31:0] e_tgt;
      logic [12:0] e_ctl;
      logic [31:0] e_rega, e_regb, e_imm, e_link;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] idx);
      return {op, idx};
   endfunction

   function automatic logic [12:0] mk_ctl(input logic rw, rm, wm, si, sl,
                                          input logic [2:0] alu, input logic [4:0] rd);
      return {rw, rm, wm, si, sl, alu, rd};
   endfunction

   task automatic addv(input logic [31:0] instr, pc, input logic stall, src,
                       input logic [1:0] typ, input logic [31:0] tgt, input logic [12:0] ctl,
                       input logic [31:0] ra, rb, im, lk);
      vec_t v;
      v.instr = instr; v.pc = pc; v.stall = stall; v.e_src = src; v.e_type = typ;
      v.e_tgt = tgt; v.e_ctl = ctl; v.e_rega = ra; v.e_regb = rb; v.e_imm = im; v.e_link = lk;
      vecs.push_back(v);
   endtask

   task automatic wb_write(input logic [4:0] idx, input logic [31:0] data);
      @(negedge clock);
      wb_id_regwrite = 1'b1; wb_id_regdest = idx; wb_id_writedata = data;
      @(posedge clock);
      #1 wb_id_regwrite = 1'b0;
   endtask

   task automatic present(input logic [31:0] instr, pc, input logic stall);
      @(negedge clock);
      if_id_instruc = instr; if_id_nextpc = pc; ex_if_stall = stall;
      #1;
   endtask

   initial begin
      // r5=7, r6=7, r7=3, r8=0x4000_0000 are seeded before the table runs
      addv(NOP_WORD, 32'h0, 0, 0, 2'b00, 0, mk_ctl(1,0,0,0,0,3'b101,5'd0), 0, 0, 0, 32'h4);
      addv(rtype(5'd5,5'd7,5'd4,5'd0,6'h20), 32'h10, 0, 0, 2'b00, 0,
           mk_ctl(1,0,0,0,0,3'b000,5'd4), 7, 3, 32'h2020, 32'h14);
      addv(rtype(5'd5,5'd7,5'd9,5'd0,6'h22), 32'h20, 0, 0, 2'b00, 0,
           mk_ctl(1,0,0,0,0,3'b001,5'd9), 7, 3, 32'h4822, 32'h24);
      addv(rtype(5'd7,5'd5,5'd10,5'd0,6'h2A), 32'h30, 0, 0, 2'b00, 0,
           mk_ctl(1,0,0,0,0,3'b100,5'd10), 3, 7, 32'h502A, 32'h34);
      addv(rtype(5'd0,5'd5,5'd11,5'd2,6'h02), 32'h40, 0, 0, 2'b00, 0,
           mk_ctl(1,0,0,0,0,3'b110,5'd11), 0, 7, 32'h5882, 32'h44);
      addv(rtype(5'd5,5'd7,5'd13,5'd0,6'h24), 32'h50, 0, 0, 2'b00, 0,
           mk_ctl(1,0,0,0,0,3'b010,5'd13), 7, 3, 32'h6824, 32'h54);
      addv(rtype(5'd5,5'd7,5'd14,5'd0,6'h25), 32'h60, 0, 0, 2'b00, 0,
           mk_ctl(1,0,0,0,0,3'b011,5'd14), 7, 3, 32'h7025, 32'h64);
      addv(itype(6'h08,5'd5,5'd1,16'hFFFC), 32'h70, 0, 0, 2'b00, 0,
           mk_ctl(1,0,0,1,0,3'b000,5'd1), 7, 0, 32'hFFFF_FFFC, 32'h74);
      addv(itype(6'h23,5'd6,5'd12,16'h0008), 32'h80, 0, 0, 2'b00, 0,
           mk_ctl(1,1,0,1,0,3'b000,5'd12), 7, 0, 32'h8, 32'h84);
      addv(itype(6'h2B,5'd5,5'd7,16'h0010), 32'h90, 0, 0, 2'b00, 0,
           mk_ctl(0,0,1,1,0,3'b000,5'd0), 7, 3, 32'h10, 32'h94);
      addv(itype(6'h04,5'd5,5'd6,16'h0003), 32'h100, 0, 1, 2'b00, 32'h110,
           mk_ctl(0,0,0,0,0,3'b001,5'd0), 7, 7, 32'h3, 32'h104);
      addv(itype(6'h04,5'd5,5'd7,16'h0003), 32'h100, 0, 0, 2'b00, 0,
           mk_ctl(0,0,0,0,0,3'b001,5'd0), 7, 3, 32'h3, 32'h104);
      addv(itype(6'h05,5'd5,5'd7,16'hFFFF), 32'h200, 0, 1, 2'b00, 32'h200,
           mk_ctl(0,0,0,0,0,3'b001,5'd0), 7, 3, 32'hFFFF_FFFF, 32'h204);
      addv(itype(6'h05,5'd5,5'd6,16'h0002), 32'h200, 0, 0, 2'b00, 0,
           mk_ctl(0,0,0,0,0,3'b001,5'd0), 7, 7, 32'h2, 32'h204);
      addv(rtype(5'd8,5'd0,5'd0,5'd0,6'h08), 32'h300, 0, 1, 2'b01, 32'h4000_0000,
           13'd0, 32'h4000_0000, 0, 32'h8, 32'h304);
      addv(jtype(6'h02,26'h40), 32'h2000_0010, 0, 1, 2'b10, 32'h2000_0100,
           13'd0, 0, 0, 32'h40, 32'h2000_0014);
      addv(jtype(6'h03,26'h40), 32'h2000_0010, 0, 1, 2'b10, 32'h2000_0100,
           mk_ctl(1,0,0,0,1,3'b000,5'd31), 0, 0, 32'h40, 32'h2000_0014);
      addv(32'hFC00_0000, 32'h400, 0, 1, 2'b11, 0, 13'd0, 0, 0, 0, 0);
      addv(rtype(5'd5,5'd6,5'd7,5'd0,6'h3F), 32'h410, 0, 1, 2'b11, 0, 13'd0, 0, 0, 0, 0);

      reset = 1'b0; if_id_instruc = NOP_WORD; if_id_nextpc = 0; ex_if_stall = 0;
      wb_id_regwrite = 0; wb_id_regdest = 0; wb_id_writedata = 0;
      #2;
      chk("reset_ctl", {19'd0, act_ctl}, 32'd0);
      chk("reset_rega", id_ex_rega, 0);
      chk("reset_regb", id_ex_regb, 0);
      chk("reset_imm", id_ex_imedext, 0);
      chk("reset_link", id_ex_nextpc, 0);
      chk("reset_src", {31'd0, id_if_selpcsource}, 0);
      @(negedge clock) reset = 1'b1;

      wb_write(5'd5, 32'd7);
      wb_write(5'd6, 32'd7);
      wb_write(5'd7, 32'd3);
      wb_write(5'd8, 32'h4000_0000);

      foreach (vecs[i]) begin
         present(vecs[i].instr, vecs[i].pc, vecs[i].stall);
         chk($sformatf("v%0d_src", i), {31'd0, id_if_selpcsource}, {31'd0, vecs[i].e_src});
         if (vecs[i].e_src) begin
            chk($sformatf("v%0d_type", i), {30'd0, id_if_selpctype}, {30'd0, vecs[i].e_type});
            case (vecs[i].e_type)
               2'b00:   chk($sformatf("v%0d_brtgt", i), id_if_pcimd2ext, vecs[i].e_tgt);
               2'b01:   chk($sformatf("v%0d_jrtgt", i), id_if_rega, vecs[i].e_tgt);
               2'b10:   chk($sformatf("v%0d_jtgt", i), id_if_pcindex, vecs[i].e_tgt);
               default: ;
            endcase
         end
         @(posedge clock); #1;
         chk($sformatf("v%0d_ctl", i), {19'd0, act_ctl}, {19'd0, vecs[i].e_ctl});
         chk($sformatf("v%0d_rega", i), id_ex_rega, vecs[i].e_rega);
         chk($sformatf("v%0d_regb", i), id_ex_regb, vecs[i].e_regb);
         chk($sformatf("v%0d_imm", i), id_ex_imedext, vecs[i].e_imm);
         chk($sformatf("v%0d_link", i), id_ex_nextpc, vecs[i].e_link);
         present(NOP_WORD, 32'h0, 1'b0);
         @(posedge clock);
      end

      // Taken beq squashes the following addi; the one after that issues normally
      present(itype(6'h04,5'd5,5'd6,16'h0003), 32'h100, 0);
      chk("sq_branch_src", {31'd0, id_if_selpcsource}, 1);
      @(posedge clock);
      present(itype(6'h08,5'd0,5'd1,16'h0009), 32'h104, 0);
      chk("sq_flush_src", {31'd0, id_if_selpcsource}, 0);
      @(posedge clock); #1;
      chk("sq_flush_ctl", {19'd0, act_ctl}, 0);
      present(itype(6'h08,5'd0,5'd1,16'h0009), 32'h110, 0);
      @(posedge clock); #1;
      chk("sq_after_ctl", {19'd0, act_ctl}, {19'd0, mk_ctl(1,0,0,1,0,3'b000,5'd1)});

      // Stall holds FLUSH, so the taken branch after it is still wrong-path
      present(itype(6'h04,5'd5,5'd6,16'h0003), 32'h100, 0);
      @(posedge clock);
      present(itype(6'h08,5'd0,5'd1,16'h0009), 32'h104, 1);
      chk("hold_stall_src", {31'd0, id_if_selpcsource}, 0);
      @(posedge clock);
      present(itype(6'h04,5'd5,5'd6,16'h0003), 32'h104, 0);
      chk("hold_flush_src", {31'd0, id_if_selpcsource}, 0);
      @(posedge clock);
      present(itype(6'h04,5'd5,5'd6,16'h0003), 32'h104, 0);
      chk("hold_normal_src", {31'd0, id_if_selpcsource}, 1);
      @(posedge clock);
      present(NOP_WORD, 32'h0, 0);
      @(posedge clock);

      // Stall beats a taken bne; FSM stays NORMAL so the replay redirects
      present(itype(6'h05,5'd5,5'd7,16'h0004), 32'h200, 1);
      chk("stall_src", {31'd0, id_if_selpcsource}, 0);
      @(posedge clock); #1;
      chk("stall_ctl", {19'd0, act_ctl}, 0);
      chk("stall_rega", id_ex_rega, 0);
      present(itype(6'h05,5'd5,5'd7,16'h0004), 32'h200, 0);
      chk("replay_src", {31'd0, id_if_selpcsource}, 1);
      chk("replay_tgt", id_if_pcimd2ext, 32'h214);
      @(posedge clock);
      present(NOP_WORD, 32'h0, 0);
      @(posedge clock);

      // Write-through bypass, then r0 write ignored
      @(negedge clock);
      if_id_instruc = rtype(5'd3,5'd0,5'd4,5'd0,6'h20); if_id_nextpc = 32'h500;
      wb_id_regwrite = 1; wb_id_regdest = 5'd3; wb_id_writedata = 32'hDEAD_BEEF;
      #1 chk("bypass_comb", id_if_rega, 32'hDEAD_BEEF);
      @(posedge clock); #1;
      chk("bypass_reg", id_ex_rega, 32'hDEAD_BEEF);
      @(negedge clock);
      wb_id_regwrite = 0;
      #1 chk("stored_r3", id_if_rega, 32'hDEAD_BEEF);
      @(negedge clock);
      if_id_instruc = rtype(5'd0,5'd0,5'd4,5'd0,6'h20);
      wb_id_regwrite = 1; wb_id_regdest = 5'd0; wb_id_writedata = 32'h1234;
      #1 chk("r0_bypass", id_if_rega, 0);
      @(posedge clock);
      @(negedge clock);
      wb_id_regwrite = 0;
      #1 chk("r0_stored", id_if_rega, 0);

      // Asynchronous reset while in FLUSH
      present(itype(6'h04,5'd5,5'd6,16'h0003), 32'h100, 0);
      @(posedge clock);
      #3 reset = 1'b0; if_id_instruc = NOP_WORD;
      #1;
      chk("arst_ctl", {19'd0, act_ctl}, 0);
      chk("arst_rega", id_ex_rega, 0);
      chk("arst_src", {31'd0, id_if_selpcsource}, 0);
      @(negedge clock);
      reset = 1'b1;
      present(itype(6'h04,5'd5,5'd7,16'h0003), 32'h100, 0);
      chk("arst_regs_clear", id_if_rega, 0);
      chk("arst_normal_src", {31'd0, id_if_selpcsource}, 1);
      @(posedge clock); #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
